// File: rtl/outlier_stream_drain.sv
// outlier_stream_drain
//   Drains the DROR controller's outlier-index FIFO (standard read mode,
//   1-cycle read latency) and re-emits the indices as one AXI4-Stream frame.
//   The frame ends with tlast once the controller reports done and the FIFO
//   has stayed quiet for SETTLE_CYCLES. A frame with no outliers is a single
//   marker beat (tdata all ones, tuser=1).
//
// Ports
//   i_clock            system clock
//   i_reset            synchronous, active-high reset
//   i_fifo_empty       controller FIFO empty
//   i_fifo_dout[N]     controller FIFO data, valid the cycle after o_fifo_rd_en
//   o_fifo_rd_en       controller FIFO read strobe
//   i_ctrl_done        controller finished (level, held until reset)
//   o_m_axis_tdata[N]  outlier index / marker
//   o_m_axis_tvalid    stream valid
//   i_m_axis_tready    stream ready
//   o_m_axis_tlast     final beat of the frame
//   o_m_axis_tuser     1 = empty-frame marker beat
//   o_outlier_count    beats accepted downstream, marker excluded (saturating)
//   o_finished         frame fully transferred, sticky until reset
//
// Build option
//   OUTLIER_STREAM_STATS_EN adds o_stall_cycles and o_underrun_cycles.
//
// States
//   S_RUN    | draining, controller still validating
//   S_SETTLE | controller done, waiting for the FIFO to stay empty
//   S_LAST   | no more input; emit the tlast beat (or the marker)
//   S_DONE   | frame complete, finished=1
module outlier_stream_drain #(
  parameter int N             = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic           i_clock,
  input  logic           i_reset,
  input  logic           i_fifo_empty,
  input  logic [N-1:0]   i_fifo_dout,
  output logic           o_fifo_rd_en,
  input  logic           i_ctrl_done,
  output logic [N-1:0]   o_m_axis_tdata,
  output logic           o_m_axis_tvalid,
  input  logic           i_m_axis_tready,
  output logic           o_m_axis_tlast,
  output logic           o_m_axis_tuser,
  output logic [2*N-1:0] o_outlier_count,
  output logic           o_finished
`ifdef OUTLIER_STREAM_STATS_EN
  ,
  output logic [2*N-1:0] o_stall_cycles,
  output logic [2*N-1:0] o_underrun_cycles
`endif
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_SETTLE = 2'd1,
    S_LAST   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0]     SETTLE_LOAD = 4'(SETTLE_CYCLES);
  localparam logic [2*N-1:0] CNT_ONE     = {{(2*N-1){1'b0}}, 1'b1};

  state_t         r_state;
  state_t         w_state_nxt;
  logic [3:0]     r_settle_cnt;
  logic [3:0]     w_settle_nxt;
  logic [N-1:0]   r_buf [2];
  logic           r_head;
  logic [1:0]     r_occ;
  logic           r_inflight;
  logic [2*N-1:0] r_count;

  logic w_draining;
  logic w_lookahead;
  logic w_rd_en;
  logic w_xfer;
  logic w_push;
  logic w_pop;

  assign w_draining  = (r_state == S_RUN) || (r_state == S_SETTLE);
  // A second entry must be known to exist before the head goes out with
  // tlast=0, since tlast cannot be revised once tvalid is up.
  assign w_lookahead = (r_occ == 2'd2) || ((r_occ == 2'd1) && r_inflight) || !i_fifo_empty;
  assign w_rd_en     = w_draining && !i_fifo_empty && ((r_occ + {1'b0, r_inflight}) < 2'd2);

  always_comb begin
    o_m_axis_tvalid = 1'b0;
    o_m_axis_tlast  = 1'b0;
    o_m_axis_tuser  = 1'b0;
    o_m_axis_tdata  = '0;
    case (r_state)
      S_RUN, S_SETTLE: begin
        if ((r_occ != 2'd0) && w_lookahead) begin
          o_m_axis_tvalid = 1'b1;
          o_m_axis_tdata  = r_buf[r_head];
        end
      end
      S_LAST: begin
        o_m_axis_tvalid = 1'b1;
        if (r_occ == 2'd0) begin
          o_m_axis_tdata = '1;
          o_m_axis_tlast = 1'b1;
          o_m_axis_tuser = 1'b1;
        end else begin
          o_m_axis_tdata = r_buf[r_head];
          o_m_axis_tlast = (r_occ == 2'd1);
        end
      end
      default: ;
    endcase
  end

  assign w_xfer = o_m_axis_tvalid && i_m_axis_tready;
  assign w_pop  = w_xfer && (r_occ != 2'd0);
  assign w_push = r_inflight;

  always_comb begin
    w_state_nxt  = r_state;
    w_settle_nxt = r_settle_cnt;
    case (r_state)
      S_RUN: begin
        if (i_ctrl_done) begin
          w_state_nxt  = S_SETTLE;
          w_settle_nxt = SETTLE_LOAD;
        end
      end
      S_SETTLE: begin
        if (!i_fifo_empty || r_inflight) begin
          w_settle_nxt = SETTLE_LOAD;
        end else if (r_settle_cnt == 4'd0) begin
          w_state_nxt = S_LAST;
        end else begin
          w_settle_nxt = r_settle_cnt - 4'd1;
        end
      end
      S_LAST: begin
        if (w_xfer && o_m_axis_tlast) w_state_nxt = S_DONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= S_RUN;
      r_settle_cnt <= '0;
      r_buf[0]     <= '0;
      r_buf[1]     <= '0;
      r_head       <= 1'b0;
      r_occ        <= 2'd0;
      r_inflight   <= 1'b0;
      r_count      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_settle_cnt <= w_settle_nxt;
      r_inflight   <= w_rd_en;
      // Write slot is the one after the head when one entry is already held.
      if (w_push) r_buf[r_head ^ r_occ[0]] <= i_fifo_dout;
      if (w_pop) r_head <= ~r_head;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: ;
      endcase
      if (w_xfer && !o_m_axis_tuser && (r_count != '1)) r_count <= r_count + CNT_ONE;
    end
  end

  assign o_fifo_rd_en    = w_rd_en;
  assign o_outlier_count = r_count;
  assign o_finished      = (r_state == S_DONE);

`ifdef OUTLIER_STREAM_STATS_EN
  logic [2*N-1:0] r_stall;
  logic [2*N-1:0] r_underrun;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_stall    <= '0;
      r_underrun <= '0;
    end else begin
      if (o_m_axis_tvalid && !i_m_axis_tready && (r_stall != '1)) r_stall <= r_stall + CNT_ONE;
      if (w_draining && (r_occ != 2'd0) && !w_lookahead && (r_underrun != '1))
        r_underrun <= r_underrun + CNT_ONE;
    end
  end

  assign o_stall_cycles    = r_stall;
  assign o_underrun_cycles = r_underrun;
`endif

endmodule

// File: tb/tb_outlier_stream_drain.sv
module tb_outlier_stream_drain;
  localparam int N = 16;

  logic           clk = 1'b0;
  logic           i_reset = 1'b1;
  logic           fifo_empty;
  logic [N-1:0]   fifo_dout = '0;
  logic           rd_en;
  logic           ctrl_done = 1'b0;
  logic [N-1:0]   tdata;
  logic           tvalid;
  logic           tready = 1'b0;
  logic           tlast;
  logic           tuser;
  logic [2*N-1:0] ocount;
  logic           finished;
`ifdef OUTLIER_STREAM_STATS_EN
  logic [2*N-1:0] stall_cycles;
  logic [2*N-1:0] underrun_cycles;
`endif

  always #5 clk = ~clk;

  outlier_stream_drain #(.N(N), .SETTLE_CYCLES(2)) dut (
    .i_clock         (clk),
    .i_reset         (i_reset),
    .i_fifo_empty    (fifo_empty),
    .i_fifo_dout     (fifo_dout),
    .o_fifo_rd_en    (rd_en),
    .i_ctrl_done     (ctrl_done),
    .o_m_axis_tdata  (tdata),
    .o_m_axis_tvalid (tvalid),
    .i_m_axis_tready (tready),
    .o_m_axis_tlast  (tlast),
    .o_m_axis_tuser  (tuser),
    .o_outlier_count (ocount),
    .o_finished      (finished)
`ifdef OUTLIER_STREAM_STATS_EN
    ,
    .o_stall_cycles    (stall_cycles),
    .o_underrun_cycles (underrun_cycles)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Controller FIFO model: standard read mode, data the cycle after rd_en.
  logic [N-1:0] mem [256];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (rd_en && (wr_ptr != rd_ptr)) begin
      fifo_dout <= mem[rd_ptr & 255];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  logic [N-1:0] exp_q [$];

  task automatic push(input logic [N-1:0] v);
    mem[wr_ptr & 255] = v;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(v);
  endtask

  // Stream monitor
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [N+1:0] got [$];
  int           last_cyc = -1;
  int           fin_cyc = -1;
  int           rd_cnt = 0;
  logic         have_prev = 1'b0;
  logic         prev_v = 1'b0;
  logic         prev_r = 1'b0;
  logic [N+1:0] prev_beat = '0;

  always @(negedge clk) begin
    if (i_reset) begin
      have_prev = 1'b0;
    end else begin
      if (have_prev && prev_v && !prev_r)
        check("axi_hold", {tvalid, tdata, tlast, tuser}, {1'b1, prev_beat});
      if (rd_en) begin
        check("rd_on_empty", fifo_empty, 0);
        rd_cnt++;
      end
      if (tvalid && tready) begin
        got.push_back({tdata, tlast, tuser});
        if (tlast) last_cyc = cyc;
      end
      if (finished && (fin_cyc < 0)) fin_cyc = cyc;
      have_prev = 1'b1;
      prev_v    = tvalid;
      prev_r    = tready;
      prev_beat = {tdata, tlast, tuser};
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    i_reset   = 1'b1;
    ctrl_done = 1'b0;
    tready    = 1'b0;
    wr_ptr    = rd_ptr;
    exp_q.delete();
    got.delete();
    last_cyc = -1;
    fin_cyc  = -1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_reset = 1'b0;
  endtask

  logic [N-1:0] cur_v [8];

  // One frame: n indices, the last `late` of them written the cycle after
  // ctrl_done rises; tready low for `stall` cycles, then always/random high.
  task automatic run_frame(input string tag, input int n, input int late, input int done_at,
                           input int stall, input int rmode);
    int npre;
    logic [N+1:0] eb [$];
    npre = n - late;
    do_reset();
    @(negedge clk);
    check({tag, "_reset_state"}, {tvalid, tlast, tuser, tdata, rd_en, finished, ocount},
          '0);
    @(posedge clk); #1;
    rd_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      if (c < npre) push(cur_v[c]);
      if (c == done_at) ctrl_done = 1'b1;
      if ((late != 0) && (c == done_at + 1)) push(cur_v[n-1]);
      if (c < stall) tready = 1'b0;
      else if (rmode == 0) tready = 1'b1;
      else tready = ($urandom_range(0, 3) != 0);
      if ((stall > 0) && (c == stall)) check({tag, "_stall_rd_pulses_le2"}, rd_cnt <= 2, 1);
      if (finished && (c > done_at + 1)) break;
      @(posedge clk); #1;
    end
    check({tag, "_finished"}, finished, 1);
    tready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    if (exp_q.size() == 0) eb.push_back({{N{1'b1}}, 1'b1, 1'b1});
    else
      for (int i = 0; i < exp_q.size(); i++)
        eb.push_back({exp_q[i], 1'(i == exp_q.size() - 1), 1'b0});
    check({tag, "_beats"}, got.size(), eb.size());
    for (int i = 0; i < eb.size() && i < got.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), got[i], eb[i]);
    check({tag, "_count"}, ocount, exp_q.size());
    check({tag, "_fin_after_last"}, fin_cyc - last_cyc, 1);
    check({tag, "_idle_after_done"}, {tvalid, rd_en, finished}, 3'b001);
  endtask

  typedef struct {
    string        tag;
    int           n;
    logic [N-1:0] v [8];
    int           late;
    int           done_at;
    int           stall;
    int           exp_cnt;
    logic [N-1:0] exp_last;
    logic         exp_user;
  } row_t;

  row_t rows [4];

  initial begin
    rows[0].tag = "three";   rows[0].n = 3; rows[0].late = 0; rows[0].done_at = 20;
    rows[0].stall = 0;       rows[0].exp_cnt = 3; rows[0].exp_last = 16'd12; rows[0].exp_user = 1'b0;
    rows[0].v[0] = 16'd5;    rows[0].v[1] = 16'd9; rows[0].v[2] = 16'd12;
    rows[1].tag = "empty";   rows[1].n = 0; rows[1].late = 0; rows[1].done_at = 3;
    rows[1].stall = 0;       rows[1].exp_cnt = 0; rows[1].exp_last = 16'hFFFF; rows[1].exp_user = 1'b1;
    rows[2].tag = "stall";   rows[2].n = 6; rows[2].late = 0; rows[2].done_at = 8;
    rows[2].stall = 10;      rows[2].exp_cnt = 6; rows[2].exp_last = 16'd6; rows[2].exp_user = 1'b0;
    for (int i = 0; i < 6; i++) rows[2].v[i] = 16'(i + 1);
    rows[3].tag = "late";    rows[3].n = 2; rows[3].late = 1; rows[3].done_at = 5;
    rows[3].stall = 0;       rows[3].exp_cnt = 2; rows[3].exp_last = 16'd42; rows[3].exp_user = 1'b0;
    rows[3].v[0] = 16'd3;    rows[3].v[1] = 16'd42;

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 8; i++) cur_v[i] = rows[r].v[i];
      run_frame(rows[r].tag, rows[r].n, rows[r].late, rows[r].done_at, rows[r].stall, 0);
      check({rows[r].tag, "_tbl_count"}, ocount, rows[r].exp_cnt);
      if (got.size() > 0)
        check({rows[r].tag, "_tbl_final"}, got[got.size()-1],
              {rows[r].exp_last, 1'b1, rows[r].exp_user});
    end

    // Reset in the middle of a frame, then a fresh frame of 7, 8.
    do_reset();
    tready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      push(16'(i));
      @(posedge clk); #1;
    end
    ctrl_done = 1'b1;
    for (int c = 0; c < 100 && got.size() < 2; c++) begin
      @(posedge clk); #1;
    end
    check("midrst_two_beats", got.size() >= 2, 1);
    if (got.size() >= 2) check("midrst_first", {got[0], got[1]}, {16'd1, 2'b00, 16'd2, 2'b00});
    i_reset   = 1'b1;
    wr_ptr    = rd_ptr;
    ctrl_done = 1'b0;
    tready    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_outputs", {tvalid, tlast, ocount, finished}, '0);
    cur_v[0] = 16'd7;
    cur_v[1] = 16'd8;
    run_frame("after_rst", 2, 0, 4, 0, 0);

    // Randomised frames against the frame-level reference model.
    for (int k = 0; k < 25; k++) begin
      int n, late;
      n    = $urandom_range(0, 6);
      late = (n > 0) ? $urandom_range(0, 1) : 0;
      for (int i = 0; i < 8; i++) cur_v[i] = 16'($urandom);
      run_frame($sformatf("rnd%0d", k), n, late, (n - late) + $urandom_range(0, 4),
                $urandom_range(0, 1) * $urandom_range(1, 6), 1);
    end

`ifdef OUTLIER_STREAM_STATS_EN
    do_reset();
    push(16'd1); push(16'd2); push(16'd3);
    for (int c = 0; c < 20 && !tvalid; c++) begin
      @(posedge clk); #1;
    end
    check("stats_tvalid_up", tvalid, 1);
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
    end
    tready = 1'b1;
    check("stats_stall7", stall_cycles, 7);
    ctrl_done = 1'b1;
    for (int c = 0; c < 50 && !finished; c++) begin
      @(posedge clk); #1;
    end
    check("stats_finished", finished, 1);
    check("stats_stall_final", stall_cycles, 7);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d mismatched so far", n_bad);
    $fatal(1);
  end

endmodule

// File: doc/outlier_stream_drain.md
Name: outlier_stream_drain

Overview:
- Downstream neighbour of the DROR controller; drains its outlier-index FIFO (standard read mode, 1-cycle read latency).
- Re-emits the indices as an AXI4-Stream frame: in-order, lossless under backpressure, with tlast on the final index once the controller signals done.
- Produces a running outlier count and a finished flag for the host-side DMA/status logic.

Parameters:
- N, 16, index width; matches the controller FIFO dout width.
- SETTLE_CYCLES, 2, cycles to wait after ctrl_done before trusting fifo_empty as final (covers FIFO write-to-empty lag); legal range 1..15.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- fifo_empty  in  1  controller FIFO empty
- fifo_dout  in  N  controller FIFO data; valid the cycle after fifo_rd_en
- fifo_rd_en  out  1  FIFO read strobe (drives controller read_fifo)
- ctrl_done  in  1  controller finished validation; level, held until reset
- m_axis_tdata  out  N  outlier point index
- m_axis_tvalid  out  1  stream valid
- m_axis_tready  in  1  stream ready
- m_axis_tlast  out  1  final beat of frame
- m_axis_tuser  out  1  1 = empty-frame marker beat
- outlier_count  out  2N  beats accepted downstream (excludes the marker)
- finished  out  1  frame fully transferred; sticky until reset

Behaviour:
- Reset values: fifo_rd_en=0, tvalid=0, tlast=0, tuser=0, tdata=0, outlier_count=0, finished=0; 2-entry buffer cleared; in-flight flag cleared; FSM=RUN.
- Reset mid-frame: discards buffered and in-flight data immediately; no partial tlast is emitted.
- Buffer: 2-entry FIFO of indices. inflight=1 the cycle after fifo_rd_en.
- fifo_rd_en = !fifo_empty && (occupancy + inflight) < 2 && state in {RUN, SETTLE}. It must never overflow the buffer.
- Lookahead rule: the buffer head is presented (tvalid=1, tlast=0) only if a second entry exists: occupancy==2, or occupancy==1 with inflight, or !fifo_empty. Otherwise the head is withheld, because tlast cannot change once tvalid is high.
- AXI rules: once tvalid=1, tdata/tlast/tuser are held until tvalid && tready. A beat transfers on tvalid && tready. No combinational path from tready to tvalid.
- FSM:
  - RUN: drain per the rules above. On ctrl_done=1, go to SETTLE and load settle_cnt=SETTLE_CYCLES.
  - SETTLE: keep draining. settle_cnt decrements each cycle and reloads to SETTLE_CYCLES whenever fifo_empty=0 or inflight=1. At settle_cnt==0 with fifo_empty=1 and inflight=0, go to LAST.
  - LAST, occupancy==1: present the head with tlast=1, tuser=0.
  - LAST, occupancy==0: present the marker tdata={N{1'b1}}, tlast=1, tuser=1. This is the zero-outlier frame.
  - LAST, occupancy==2: present normally until one entry remains. An occupancy-2 entry into LAST is legal when no backpressure lookahead beat has fired.
  - LAST: on the transfer of the tlast beat, go to DONE.
  - DONE: finished=1, tvalid=0, fifo_rd_en=0. Stays here until reset; further ctrl_done or FIFO activity is ignored.
- outlier_count increments by 1 on each transfer with tuser=0. It saturates at all-ones.
- Simultaneous events: a buffer push (read return) and pop (transfer) in the same cycle keeps occupancy unchanged. If ctrl_done rises in the same cycle as a read return, the data is kept.
- Latency: a FIFO entry reaches tvalid at best 2 cycles after fifo_rd_en, subject to the lookahead rule.

Optional Feature:
- OUTLIER_STREAM_STATS_EN defined:
  - adds output stall_cycles [2N-1:0], counting cycles with tvalid=1 && tready=0 (saturating, cleared by reset);
  - adds output underrun_cycles [2N-1:0], counting RUN/SETTLE cycles where the head is withheld by the lookahead rule.
- Undefined: both ports and counters are absent; all other behaviour is identical.

Test Plan:
- FIFO preloaded with 5, 9, 12; ctrl_done=1 at cycle 20; tready=1 -> beats 5, 9, 12 in order; tlast only on 12; tuser=0 throughout; outlier_count=3; finished=1 one cycle after the 12 transfer.
- Empty FIFO, ctrl_done=1 -> exactly one beat tdata=16'hFFFF, tlast=1, tuser=1 after SETTLE; outlier_count=0; finished=1.
- FIFO holds 1..6, tready=0 for 10 cycles then 1 -> fifo_rd_en pulses at most twice during the stall; tdata held stable; all six beats arrive in order 1..6; tlast on 6.
- ctrl_done=1 while a FIFO write is still landing (fifo_empty deasserts 1 cycle after done) -> the late index is streamed with tlast; no premature marker beat.
- Reset asserted after 2 of 4 beats -> next cycle tvalid=0, outlier_count=0, finished=0; a new frame of 7, 8 then streams cleanly with tlast on 8.
- With OUTLIER_STREAM_STATS_EN and tready held low 7 cycles while tvalid=1 -> stall_cycles=7.
